// File: rtl/fp_issue_retire.sv
// Issue/retire controller for the FP multiply/divide datapath: credit-based issue,
// fixed-latency tag pipe, in-order result FIFO. Macro FP_SPECIAL_CASE_EN adds zero/inf/NaN override.
module fp_issue_retire #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sel,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_sel,
    output logic        md_en,
    input  logic [31:0] md_r,
    input  logic        md_dz,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r,
    output logic        out_nv,
    output logic        out_dz
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCW = $clog2(DEPTH + 1);
    localparam logic [OCW-1:0] DEPTH_C = OCW'(DEPTH);

    typedef struct packed {
        logic        vld;
`ifdef FP_SPECIAL_CASE_EN
        logic        ovr;
        logic [31:0] val;
        logic        nv;
        logic        dz;
`endif
    } tag_t;

    logic [31:0]    md_a_q, md_b_q;
    logic           md_sel_q, md_en_q;
    logic [OCW-1:0] occ_q, occ_d;
    tag_t           tag_q [LATENCY+1];
    tag_t           new_tag;

    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCW-1:0] cnt_q, cnt_d;
    logic [31:0]    r_mem_q  [DEPTH];
    logic           nv_mem_q [DEPTH];
    logic           dz_mem_q [DEPTH];

    logic           accept, pop, push;
    logic [31:0]    push_r;
    logic           push_nv, push_dz;

    // The datapath's own divide-by-zero flag is superseded by operand classification.
    logic           unused_md_dz;
    assign unused_md_dz = md_dz;

    assign md_a      = md_a_q;
    assign md_b      = md_b_q;
    assign md_sel    = md_sel_q;
    assign md_en     = md_en_q;

    // md_en_q doubles as "out of reset" so in_ready is 0 during reset without a combinational path.
    assign in_ready  = md_en_q && (occ_q < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = tag_q[LATENCY].vld;

    assign out_r     = r_mem_q[rd_ptr_q];
    assign out_nv    = nv_mem_q[rd_ptr_q];
    assign out_dz    = dz_mem_q[rd_ptr_q];

`ifdef FP_SPECIAL_CASE_EN
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn;

    // Denormals are flushed: any zero exponent counts as zero.
    assign a_zero = (in_a[30:23] == 8'h00);
    assign a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
    assign a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
    assign b_zero = (in_b[30:23] == 8'h00);
    assign b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
    assign b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
    assign sgn    = in_a[31] ^ in_b[31];

    always_comb begin
        new_tag     = '0;
        new_tag.vld = 1'b1;
        if (in_sel) begin
            if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                new_tag.ovr = 1'b1;
                new_tag.val = 32'h7FC0_0000;
                new_tag.nv  = 1'b1;
            end else if (a_inf || b_inf) begin
                new_tag.ovr = 1'b1;
                new_tag.val = {sgn, 8'hFF, 23'd0};
            end else if (a_zero || b_zero) begin
                new_tag.ovr = 1'b1;
                new_tag.val = {sgn, 31'd0};
            end
        end else begin
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                new_tag.ovr = 1'b1;
                new_tag.val = 32'h7FC0_0000;
                new_tag.nv  = 1'b1;
            end else if (a_inf) begin
                new_tag.ovr = 1'b1;
                new_tag.val = {sgn, 8'hFF, 23'd0};
            end else if (b_zero) begin
                new_tag.ovr = 1'b1;
                new_tag.val = {sgn, 8'hFF, 23'd0};
                new_tag.dz  = 1'b1;
            end else if (a_zero || b_inf) begin
                new_tag.ovr = 1'b1;
                new_tag.val = {sgn, 31'd0};
            end
        end
    end

    assign push_r  = tag_q[LATENCY].ovr ? tag_q[LATENCY].val : md_r;
    assign push_nv = tag_q[LATENCY].nv;
    assign push_dz = tag_q[LATENCY].dz;
`else
    always_comb begin
        new_tag     = '0;
        new_tag.vld = 1'b1;
    end

    assign push_r  = md_r;
    assign push_nv = 1'b0;
    assign push_dz = 1'b0;
`endif

    // Occupancy counts in-flight plus queued results; a tag moving into the FIFO leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + OCW'(1);
        end else if (!accept && pop) begin
            occ_d = occ_q - OCW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + OCW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - OCW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            md_a_q   <= '0;
            md_b_q   <= '0;
            md_sel_q <= 1'b0;
            md_en_q  <= 1'b0;
            occ_q    <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            md_en_q <= 1'b1;
            occ_q   <= occ_d;
            if (accept) begin
                md_a_q   <= in_a;
                md_b_q   <= in_b;
                md_sel_q <= in_sel;
            end
            tag_q[0] <= accept ? new_tag : '0;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Credits guarantee a free slot whenever a tag exits, so push never checks for full.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i]  <= '0;
                nv_mem_q[i] <= 1'b0;
                dz_mem_q[i] <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                r_mem_q[wr_ptr_q]  <= push_r;
                nv_mem_q[wr_ptr_q] <= push_nv;
                dz_mem_q[wr_ptr_q] <= push_dz;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_retire.sv
// Bench for fp_issue_retire: behavioural datapath stand-in plus an operand-level result model.
// Expectations follow FP_SPECIAL_CASE_EN the same way the design build does.
module tb_fp_issue_retire;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 4;

    logic        clk;
    logic        arst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_sel;
    logic [31:0] md_a, md_b;
    logic        md_sel, md_en;
    logic [31:0] md_r;
    logic        md_dz;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic        out_nv, out_dz;

    fp_issue_retire #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_sel    (md_sel),
        .md_en     (md_en),
        .md_r      (md_r),
        .md_dz     (md_dz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_nv    (out_nv),
        .out_dz    (out_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        nv;
        logic        dz;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
    } op_t;

    int   checks = 0;
    int   errors = 0;
    int   occ    = 0;
    res_t exp_q[$];
    res_t got_q[$];
    op_t  pend[$];

    // Datapath stand-in: single -> double, real arithmetic, back to single (flush/saturate).
    function automatic logic [63:0] s2d(input logic [31:0] x);
        logic [10:0] e;
        e = (x[30:23] == 8'h00) ? 11'd0 : 11'(x[30:23]) + 11'd896;
        return {x[31], e, x[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        int e;
        e = int'(d[62:52]);
        if (e < 897) return {d[63], 31'd0};
        if (e > 1150) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b, input logic sel);
        real ra, rb;
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(b));
        return d2s($realtobits(sel ? ra * rb : ra / rb));
    endfunction

    logic [64:0] dp_st [LATENCY];
    always @(posedge clk) begin
        dp_st[0] <= {md_sel, md_a, md_b};
        for (int i = 1; i < LATENCY; i++) dp_st[i] <= dp_st[i-1];
    end
    assign md_r  = dp_fn(dp_st[LATENCY-1][63:32], dp_st[LATENCY-1][31:0], dp_st[LATENCY-1][64]);
    assign md_dz = !dp_st[LATENCY-1][64] && (dp_st[LATENCY-1][30:23] == 8'h00);

`ifdef FP_SPECIAL_CASE_EN
    // Operand kinds: 0 zero, 1 finite, 2 inf, 3 NaN. Outcome: 0 datapath, 1 signed zero,
    // 2 signed inf, 3 quiet NaN + nv, 4 signed inf + dz. Indexed [kind(a)][kind(b)].
    localparam int MUL_T [4][4] = '{'{1, 1, 3, 3}, '{1, 0, 2, 3}, '{3, 2, 2, 3}, '{3, 3, 3, 3}};
    localparam int DIV_T [4][4] = '{'{3, 1, 1, 3}, '{4, 0, 1, 3}, '{2, 2, 3, 3}, '{3, 3, 3, 3}};

    function automatic int kind(input logic [31:0] x);
        if (x[30:23] == 8'h00) return 0;
        if (x[30:23] != 8'hFF) return 1;
        return (x[22:0] == 23'd0) ? 2 : 3;
    endfunction
`endif

    function automatic res_t ref_fn(input logic [31:0] a, input logic [31:0] b, input logic sel);
        res_t e;
        e.r  = dp_fn(a, b, sel);
        e.nv = 1'b0;
        e.dz = 1'b0;
`ifdef FP_SPECIAL_CASE_EN
        begin
            int   code;
            logic s;
            s    = a[31] ^ b[31];
            code = sel ? MUL_T[kind(a)][kind(b)] : DIV_T[kind(a)][kind(b)];
            case (code)
                1: e.r = {s, 31'd0};
                2: e.r = {s, 8'hFF, 23'd0};
                3: begin e.r = 32'h7FC0_0000; e.nv = 1'b1; end
                4: begin e.r = {s, 8'hFF, 23'd0}; e.dz = 1'b1; end
                default: ;
            endcase
        end
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [7:0]  e;
        int          k;
        r = $urandom();
        e = 8'($urandom_range(100, 150));
        k = $urandom_range(0, 9);
        case (k)
            0: return {r[31], 31'd0};
            1: return {r[31], 8'hFF, 23'd0};
            2: return {r[31], 8'hFF, r[22:0] | 23'd1};
            3: return {r[31], 8'h00, r[22:0]};
            default: return {r[31], e, r[22:0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_md_a"},      md_a, 32'd0);
        check({tag, "_md_b"},      md_b, 32'd0);
        check({tag, "_md_sel"},    32'(md_sel), 32'd0);
        check({tag, "_md_en"},     32'(md_en), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_r"},     out_r, 32'd0);
        check({tag, "_out_nv"},    32'(out_nv), 32'd0);
        check({tag, "_out_dz"},    32'(out_dz), 32'd0);
    endtask

    // One cycle, entered #1 after a rising edge; handshakes complete at the next edge.
    task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b, input logic sel,
                        input bit ordy, output bit acc);
        res_t e;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_sel    = sel;
        out_ready = ordy;
        acc       = 1'b0;
        check("in_ready", 32'(in_ready), 32'(occ < DEPTH));
        if (exp_q.size() == 0) check("out_valid_idle", 32'(out_valid), 32'd0);
        if (out_valid && ordy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_r",  out_r, e.r);
            check("out_nv", 32'(out_nv), 32'(e.nv));
            check("out_dz", 32'(out_dz), 32'(e.dz));
            got_q.push_back({out_r, out_nv, out_dz});
            occ--;
        end
        if (iv && in_ready) begin
            exp_q.push_back(ref_fn(a, b, sel));
            occ++;
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready held 1; mode 1: out_ready random.
    task automatic run(input int mode, input int budget);
        int  n;
        bit  acc, ordy;
        op_t o;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            ordy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            o    = (pend.size() > 0) ? pend[0] : '0;
            step(pend.size() > 0, o.a, o.b, o.sel, ordy, acc);
            if (acc) void'(pend.pop_front());
            n++;
        end
        in_valid = 1'b0;
        check("run_budget", 32'(pend.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   acc;
        int   accepted;
        res_t sp_exp [4];
        op_t  sp_op  [4];

        arst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        arst = 1'b1;
        @(posedge clk);
        #1;
        check("md_en_after_reset", 32'(md_en), 32'd1);

        // Single multiply and first-result latency.
        in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4040_0000; in_sel = 1'b1;
        check("single_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("single_md_a",   md_a, 32'h4000_0000);
        check("single_md_b",   md_b, 32'h4040_0000);
        check("single_md_sel", 32'(md_sel), 32'd1);
        for (int k = 1; k <= LATENCY + 1; k++) begin
            @(posedge clk);
            #1;
            check("single_latency", 32'(out_valid), 32'(k == LATENCY + 1));
        end
        check("single_out_r",  out_r, 32'h40C0_0000);
        check("single_out_nv", 32'(out_nv), 32'd0);
        check("single_out_dz", 32'(out_dz), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("single_popped", 32'(out_valid), 32'd0);

        // Backpressure: 8 offered against 4 credits with the consumer stalled.
        for (int i = 0; i < 8; i++) pend.push_back({rand_op(), rand_op(), 1'($urandom_range(0, 1))});
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            op_t o;
            o = pend[0];
            step(1'b1, o.a, o.b, o.sel, 1'b0, acc);
            if (acc) begin
                void'(pend.pop_front());
                accepted++;
            end
        end
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        got_q.delete();
        run(0, 200);
        check("bp_retired", 32'(got_q.size()), 32'd8);

        // Special operands, checked against the literal outcomes as well as the model.
        sp_op[0] = {32'h3F80_0000, 32'h0000_0000, 1'b0};
        sp_op[1] = {32'h0000_0000, 32'h0000_0000, 1'b0};
        sp_op[2] = {32'hFF80_0000, 32'h0000_0000, 1'b1};
        sp_op[3] = {32'h8000_0000, 32'h4000_0000, 1'b1};
`ifdef FP_SPECIAL_CASE_EN
        sp_exp[0] = {32'h7F80_0000, 1'b0, 1'b1};
        sp_exp[1] = {32'h7FC0_0000, 1'b1, 1'b0};
        sp_exp[2] = {32'h7FC0_0000, 1'b1, 1'b0};
        sp_exp[3] = {32'h8000_0000, 1'b0, 1'b0};
`else
        for (int i = 0; i < 4; i++) sp_exp[i] = {dp_fn(sp_op[i].a, sp_op[i].b, sp_op[i].sel), 1'b0, 1'b0};
`endif
        got_q.delete();
        for (int i = 0; i < 4; i++) pend.push_back(sp_op[i]);
        run(0, 100);
        check("sp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check($sformatf("sp%0d_r", i),  got_q[i].r, sp_exp[i].r);
            check($sformatf("sp%0d_nv", i), 32'(got_q[i].nv), 32'(sp_exp[i].nv));
            check($sformatf("sp%0d_dz", i), 32'(got_q[i].dz), 32'(sp_exp[i].dz));
        end

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) step(1'b1, rand_op(), rand_op(), 1'b1, 1'b1, acc);
        in_valid = 1'b0;
        arst = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        pend.delete();
        occ = 0;
        @(posedge clk);
        #1;
        arst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) begin
            check("midrst_no_valid", 32'(out_valid), 32'd0);
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        end
        got_q.delete();
        pend.push_back({32'h4000_0000, 32'h4040_0000, 1'b1});
        run(0, 50);
        check("midrst_next_op", 32'(got_q.size()), 32'd1);

        // Streaming with random operands and random consumer stalls.
        got_q.delete();
        for (int i = 0; i < 100; i++) pend.push_back({rand_op(), rand_op(), 1'($urandom_range(0, 1))});
        run(1, 3000);
        check("stream_count", 32'(got_q.size()), 32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
